uart_tx_scheduler: RTL
======================

Name: uart_tx_scheduler

Overview:
- Shares the single uart transmitter between NUM_REQ independent requesters using round-robin arbitration.
- Sequences the uart's transmit handshake (tx pulse, tx_busy rise/fall).
- Serialises uart reconfiguration (config_set/config_ack) so it only occurs while the transmitter is idle.
- Sits directly in front of the uart tx/config ports; requesters never drive the uart directly.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- TIMEOUT, 4096, max cycles to wait for uart_tx_busy rise or uart_config_ack before abort.
- TIMEOUT_WIDTH, 13, counter width; must hold TIMEOUT.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  NUM_REQ  per-requester byte pending; held with req_data until req_ack
- req_data  in  NUM_REQ*9  requester i data in bits [9i+8:9i]
- req_ack  out  NUM_REQ  one-cycle pulse: requester's byte captured and issued
- cfg_req  in  1  level request to apply new uart config; held until cfg_done
- cfg_done  out  1  one-cycle pulse: uart acknowledged config
- uart_tx_data  out  9  to uart tx_data
- uart_tx  out  1  to uart tx, one-cycle pulse
- uart_tx_busy  in  1  from uart tx_busy
- uart_config_set  out  1  to uart config_set
- uart_config_ack  in  1  from uart config_ack
- grant_id  out  $clog2(NUM_REQ)  index of last granted requester
- err_timeout  out  1  one-cycle pulse on handshake timeout

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=IDLE; all outputs 0; uart_tx_data=0.
  - rr pointer=NUM_REQ-1, so requester 0 wins first; cfg_first=1; timeout counter=0.
  - Reset mid-transfer abandons it; no req_ack or cfg_done is issued afterwards.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, CFG_SET.
- IDLE, only when uart_tx_busy=0:
  - If cfg_req=1 and (cfg_first=1 or req_valid==0): go to CFG_SET.
  - Else if any req_valid: select g = first set bit searching from pointer+1 mod NUM_REQ, wrapping. Register uart_tx_data=req_data[g]; pointer=g; grant_id=g; go to ISSUE.
  - If uart_tx_busy=1 in IDLE: stay in IDLE.
- ISSUE, exactly one cycle:
  - uart_tx=1 and req_ack[g]=1; go to WAIT_BUSY; clear timeout counter.
  - Latency: valid seen in IDLE at cycle t -> uart_tx and req_ack at t+1.
- WAIT_BUSY:
  - If uart_tx_busy=1: go to WAIT_DONE. A busy that is already high in the cycle after ISSUE counts.
  - Else increment counter; at TIMEOUT-1 pulse err_timeout and go to IDLE.
- WAIT_DONE: on uart_tx_busy=0 go to IDLE; cfg_first=1. No timeout here.
- CFG_SET:
  - uart_config_set=1 held while in state.
  - On uart_config_ack=1: deassert config_set next cycle, pulse cfg_done, cfg_first=0, go to IDLE.
  - Timeout as in WAIT_BUSY: err_timeout pulse, config_set dropped, no cfg_done, go to IDLE. cfg_req still high retries.
- Fairness:
  - Config and data alternate when both pending: after a config, one data grant is served before another config is accepted.
  - Round-robin guarantees each valid requester is served within NUM_REQ grants.
- req_valid dropping before ack is permitted; arbitration uses only the current cycle's value in IDLE.
- uart_tx_data holds its value after ISSUE until the next grant.
- At most one outstanding uart operation at any time. uart_tx and uart_config_set are never both 1.

Decomposition:
- Shared package uart_pkg:
  - UART_DATA_W=9.
  - enum sched_state_t {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, CFG_SET}.
  - Default TIMEOUT constant.
- Sub-module rr_arbiter (parameter N): inputs req vector and pointer; outputs one-hot grant, index, any. Purely combinational, reusable by future uart rx/dma blocks.

Test Plan:
- Single requester: req_valid=0001, data=0x0A5 -> uart_tx pulse 1 cycle after IDLE sample, uart_tx_data=0x0A5, req_ack=0001 same cycle; no further tx until busy falls.
- All four valid continuously -> grant order 0,1,2,3,0; each req_ack exactly once per uart frame; grant_id matches.
- Wrap-around: pointer=3, req_valid=1010 -> grant 1; then grant 3; then grant 1.
- cfg_req during an active frame -> config_set only after tx_busy falls. With ack after 5 cycles, cfg_done pulses once. With data pending throughout, sequence is cfg, data, cfg.
- Stub uart never raises tx_busy -> err_timeout pulse exactly TIMEOUT cycles after ISSUE, FSM back to IDLE, next requester granted.
- rst_n=0 for one cycle during WAIT_DONE -> all outputs 0 next cycle; after release, requester 0 is granted first.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the uart transmit-side blocks.
package uart_pkg;

  localparam int unsigned UART_DATA_W     = 9;
  localparam int unsigned TIMEOUT_DEFAULT = 4096;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    CFG_SET
  } sched_state_t;

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: searches from ptr+1 upward, wrapping,
// and returns the first requester found as one-hot, index and any flag.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int unsigned j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      j = (32'(ptr) + i) % N;
      if (!any && req[j[IW-1:0]]) begin
        any              = 1'b1;
        grant[j[IW-1:0]] = 1'b1;
        idx              = j[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one uart transmitter between NUM_REQ requesters (round-robin) and
// serialises uart reconfiguration so it only happens while tx is idle.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned TIMEOUT       = TIMEOUT_DEFAULT,
  parameter int unsigned TIMEOUT_WIDTH = 13
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*UART_DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ack,
  input  logic                           cfg_req,
  output logic                           cfg_done,
  output logic [UART_DATA_W-1:0]         uart_tx_data,
  output logic                           uart_tx,
  input  logic                           uart_tx_busy,
  output logic                           uart_config_set,
  input  logic                           uart_config_ack,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           err_timeout
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam logic [TIMEOUT_WIDTH-1:0] CNT_LAST = TIMEOUT_WIDTH'(TIMEOUT - 1);

  sched_state_t               state_q, state_d;
  logic [IW-1:0]              ptr_q, ptr_d;
  logic [IW-1:0]              gid_q, gid_d;
  logic [UART_DATA_W-1:0]     data_q, data_d;
  logic [TIMEOUT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                       cfg_first_q, cfg_first_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IW-1:0]      arb_idx;
  logic               arb_any;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    gid_d           = gid_q;
    data_d          = data_q;
    cnt_d           = cnt_q;
    cfg_first_d     = cfg_first_q;
    uart_tx         = 1'b0;
    req_ack         = '0;
    cfg_done        = 1'b0;
    uart_config_set = 1'b0;
    err_timeout     = 1'b0;
    case (state_q)
      IDLE: begin
        // cfg_first makes config and data alternate when both are pending
        if (!uart_tx_busy) begin
          if (cfg_req && (cfg_first_q || !(|req_valid))) begin
            state_d = CFG_SET;
            cnt_d   = '0;
          end else if (arb_any) begin
            data_d  = req_data[32'(arb_idx)*UART_DATA_W +: UART_DATA_W];
            ptr_d   = arb_idx;
            gid_d   = arb_idx;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        uart_tx        = 1'b1;
        req_ack[gid_q] = 1'b1;
        cnt_d          = '0;
        state_d        = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (uart_tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_timeout = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + TIMEOUT_WIDTH'(1);
        end
      end
      WAIT_DONE: begin
        if (!uart_tx_busy) begin
          cfg_first_d = 1'b1;
          state_d     = IDLE;
        end
      end
      CFG_SET: begin
        uart_config_set = 1'b1;
        if (uart_config_ack) begin
          cfg_done    = 1'b1;
          cfg_first_d = 1'b0;
          state_d     = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          err_timeout = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + TIMEOUT_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= IW'(NUM_REQ - 1);
      gid_q       <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      cfg_first_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gid_q       <= gid_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      cfg_first_q <= cfg_first_d;
    end
  end

  assign uart_tx_data = data_q;
  assign grant_id     = gid_q;

endmodule
